mem_port_arbiter_rv32: RTL and testbench

- Shares the core's single memory port between two requesters: instruction fetch (read-only) and the MEM stage (data load/store).
- Arbitrates between them with data priority and a fetch anti-starvation limit.
- Steers byte lanes for sub-word accesses, detects misaligned data accesses, and aborts stalled bus transactions with a timeout.
- Sits between the pipeline stages and the external memory/bus interface.

---
 rtl/mem_port_arbiter_rv32.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter_rv32.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_rv32.sv
// Shares one memory port between instruction fetch and the MEM stage.
// Data has priority; a streak limit keeps fetch from starving. All outputs registered.
module mem_port_arbiter_rv32 #(
  parameter int TIMEOUT     = 16,
  parameter int MAX_DSTREAK = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIFREQ,
  input  logic [29:0] iIFADDR,
  output logic [31:0] oIFRDATA,
  output logic        oIFDONE,
  output logic        oIFERR,
  input  logic        iDREQ,
  input  logic        iDRW,
  input  logic [31:0] iDADDR,
  input  logic [1:0]  iDSIZE,
  input  logic [31:0] iDWDATA,
  output logic [31:0] oDRDATA,
  output logic        oDDONE,
  output logic        oDERR,
  output logic        oMREQ,
  output logic        oMRW,
  output logic [31:0] oMADDR,
  output logic [31:0] oMWDATA,
  output logic [3:0]  oMBE,
  input  logic [31:0] iMRDATA,
  input  logic        iMRDY,
  output logic        oBUSY
);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} stateT;

  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  stateT      state;
  logic [7:0] toCnt;
  logic [3:0] streak;

  logic        accessBad;
  logic        grantI;
  logic        grantD;
  logic [3:0]  laneBe;
  logic [31:0] laneData;

  assign accessBad = (iDSIZE == 2'b11)
                   | ((iDSIZE == 2'b01) & iDADDR[0])
                   | ((iDSIZE == 2'b10) & (iDADDR[1:0] != 2'b00));

  // Fetch wins only when data is idle or data has used up its streak.
  assign grantI = iIFREQ & (~iDREQ | (streak == STREAK_MAX));
  assign grantD = iDREQ & ~grantI;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      localparam logic [1:0] LANE = 2'(gi);
      assign laneBe[gi] = (iDSIZE == 2'b00) ? (iDADDR[1:0] == LANE) :
                          (iDSIZE == 2'b01) ? (iDADDR[1] == LANE[1]) : 1'b1;
      assign laneData[gi*8 +: 8] = (iDSIZE == 2'b00) ? iDWDATA[7:0] :
                                   (iDSIZE == 2'b01) ? iDWDATA[(gi%2)*8 +: 8] :
                                                       iDWDATA[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      toCnt    <= 8'd0;
      streak   <= 4'd0;
      oIFRDATA <= 32'd0;
      oIFDONE  <= 1'b0;
      oIFERR   <= 1'b0;
      oDRDATA  <= 32'd0;
      oDDONE   <= 1'b0;
      oDERR    <= 1'b0;
      oMREQ    <= 1'b0;
      oMRW     <= 1'b0;
      oMADDR   <= 32'd0;
      oMWDATA  <= 32'd0;
      oMBE     <= 4'd0;
      oBUSY    <= 1'b0;
    end else begin
      oIFDONE <= 1'b0;
      oIFERR  <= 1'b0;
      oDDONE  <= 1'b0;
      oDERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (grantI) begin
            state   <= BUS_I;
            streak  <= 4'd0;
            toCnt   <= 8'd0;
            oMREQ   <= 1'b1;
            oMRW    <= 1'b1;
            oMADDR  <= {iIFADDR, 2'b00};
            oMBE    <= 4'hF;
            oMWDATA <= 32'd0;
            oBUSY   <= 1'b1;
          end else if (grantD) begin
            oBUSY <= 1'b1;
            if (iIFREQ && (streak != STREAK_MAX)) begin
              streak <= streak + 4'd1;
            end
            // Bad accesses never touch the bus.
            if (accessBad) begin
              state   <= RESP;
              oDDONE  <= 1'b1;
              oDERR   <= 1'b1;
              oDRDATA <= 32'd0;
            end else begin
              state   <= BUS_D;
              toCnt   <= 8'd0;
              oMREQ   <= 1'b1;
              oMRW    <= iDRW;
              oMADDR  <= {iDADDR[31:2], 2'b00};
              oMBE    <= laneBe;
              oMWDATA <= laneData;
            end
          end
        end
        BUS_I, BUS_D: begin
          if (iMRDY || (toCnt == TO_LAST)) begin
            state   <= RESP;
            oMREQ   <= 1'b0;
            oMRW    <= 1'b0;
            oMADDR  <= 32'd0;
            oMWDATA <= 32'd0;
            oMBE    <= 4'd0;
            if (state == BUS_D) begin
              oDDONE  <= 1'b1;
              oDERR   <= ~iMRDY;
              oDRDATA <= iMRDY ? iMRDATA : 32'd0;
            end else begin
              oIFDONE  <= 1'b1;
              oIFERR   <= ~iMRDY;
              oIFRDATA <= iMRDY ? iMRDATA : 32'd0;
            end
          end else begin
            toCnt <= toCnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter_rv32.sv
// Directed bench for mem_port_arbiter_rv32: a transaction-level model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_mem_port_arbiter_rv32;

  localparam int TIMEOUT     = 16;
  localparam int MAX_DSTREAK = 4;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iIFREQ = 1'b0;
  logic [29:0] iIFADDR = '0;
  logic [31:0] oIFRDATA;
  logic        oIFDONE;
  logic        oIFERR;
  logic        iDREQ = 1'b0;
  logic        iDRW = 1'b0;
  logic [31:0] iDADDR = '0;
  logic [1:0]  iDSIZE = '0;
  logic [31:0] iDWDATA = '0;
  logic [31:0] oDRDATA;
  logic        oDDONE;
  logic        oDERR;
  logic        oMREQ;
  logic        oMRW;
  logic [31:0] oMADDR;
  logic [31:0] oMWDATA;
  logic [3:0]  oMBE;
  logic [31:0] iMRDATA = '0;
  logic        iMRDY = 1'b0;
  logic        oBUSY;

  mem_port_arbiter_rv32 #(.TIMEOUT(TIMEOUT), .MAX_DSTREAK(MAX_DSTREAK)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIFREQ(iIFREQ), .iIFADDR(iIFADDR), .oIFRDATA(oIFRDATA), .oIFDONE(oIFDONE), .oIFERR(oIFERR),
    .iDREQ(iDREQ), .iDRW(iDRW), .iDADDR(iDADDR), .iDSIZE(iDSIZE), .iDWDATA(iDWDATA),
    .oDRDATA(oDRDATA), .oDDONE(oDDONE), .oDERR(oDERR),
    .oMREQ(oMREQ), .oMRW(oMRW), .oMADDR(oMADDR), .oMWDATA(oMWDATA), .oMBE(oMBE),
    .iMRDATA(iMRDATA), .iMRDY(iMRDY), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: answers after memWait cycles of oMREQ (-1 = never).
  int   memWait   = 0;
  int   busIdx    = 0;
  bit   strayRdy  = 0;
  logic [31:0] rdPattern = 32'h0;

  initial begin
    forever begin
      @(negedge iCLK);
      if (oMREQ) begin
        iMRDY = (memWait >= 0) && (busIdx == memWait);
        busIdx++;
      end else begin
        iMRDY  = strayRdy;
        busIdx = 0;
      end
      iMRDATA = rdPattern;
    end
  end

  // Transaction-level model: phase 0 idle, 1 on the bus, 2 reporting.
  int          mPhase = 0;
  bit          mIsData = 0;
  int          mBusCycles = 0;
  int          mStreak = 0;
  bit          modelLive = 0;
  logic        eMREQ = 0, eMRW = 0, eIFDONE = 0, eIFERR = 0, eDDONE = 0, eDERR = 0, eBUSY = 0;
  logic [31:0] eMADDR = 0, eMWDATA = 0, eIFRDATA = 0, eDRDATA = 0;
  logic [3:0]  eMBE = 0;

  task automatic modelFinish(input logic [31:0] rd, input logic err);
    mPhase  = 2;
    eMREQ   = 0; eMRW = 0; eMADDR = 0; eMWDATA = 0; eMBE = 0;
    if (mIsData) begin eDDONE = 1; eDERR = err; eDRDATA = rd; end
    else begin eIFDONE = 1; eIFERR = err; eIFRDATA = rd; end
  endtask

  initial begin
    forever begin
      @(posedge iCLK);
      if (iRST) begin
        mPhase = 0; mStreak = 0; mBusCycles = 0;
        eMREQ = 0; eMRW = 0; eMADDR = 0; eMWDATA = 0; eMBE = 0;
        eIFDONE = 0; eIFERR = 0; eDDONE = 0; eDERR = 0; eBUSY = 0;
        eIFRDATA = 0; eDRDATA = 0;
      end else begin
        eIFDONE = 0; eIFERR = 0; eDDONE = 0; eDERR = 0;
        if (mPhase == 0) begin
          if (iIFREQ && (!iDREQ || mStreak == MAX_DSTREAK)) begin
            mIsData = 0; mPhase = 1; mBusCycles = 0; mStreak = 0; eBUSY = 1;
            eMREQ = 1; eMRW = 1; eMADDR = {iIFADDR, 2'b00}; eMBE = 4'hF; eMWDATA = 0;
          end else if (iDREQ) begin
            int nb;
            int off;
            nb  = 1 << iDSIZE;
            off = int'(iDADDR % 4);
            mIsData = 1; eBUSY = 1;
            if (iIFREQ && mStreak < MAX_DSTREAK) mStreak++;
            if (iDSIZE == 2'b11 || (off % nb) != 0) begin
              modelFinish(32'h0, 1'b1);
            end else begin
              mPhase = 1; mBusCycles = 0;
              eMREQ = 1; eMRW = iDRW; eMADDR = iDADDR - 32'(off);
              eMBE = 4'(((1 << nb) - 1) << off);
              for (int b = 0; b < 4; b++) eMWDATA[b*8 +: 8] = iDWDATA[(b % nb)*8 +: 8];
            end
          end
        end else if (mPhase == 1) begin
          mBusCycles++;
          if (iMRDY) modelFinish(iMRDATA, 1'b0);
          else if (mBusCycles == TIMEOUT) modelFinish(32'h0, 1'b1);
        end else begin
          mPhase = 0; eBUSY = 0;
        end
      end
      modelLive = 1;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge iCLK);
      if (modelLive) begin
        chk("mreq", 32'(oMREQ), 32'(eMREQ));
        chk("mrw", 32'(oMRW), 32'(eMRW));
        chk("maddr", oMADDR, eMADDR);
        chk("mwdata", oMWDATA, eMWDATA);
        chk("mbe", 32'(oMBE), 32'(eMBE));
        chk("ifdone", 32'(oIFDONE), 32'(eIFDONE));
        chk("iferr", 32'(oIFERR), 32'(eIFERR));
        chk("ifrdata", oIFRDATA, eIFRDATA);
        chk("ddone", 32'(oDDONE), 32'(eDDONE));
        chk("derr", 32'(oDERR), 32'(eDERR));
        chk("drdata", oDRDATA, eDRDATA);
        chk("busy", 32'(oBUSY), 32'(eBUSY));
      end
    end
  end

  // Waits (bounded) at negedges until the selected output is high.
  task automatic waitFor(input int which, input int maxc, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < maxc && !hit; i++) begin
      if ((which == 0 && oMREQ) || (which == 1 && oIFDONE) || (which == 2 && oDDONE)) hit = 1;
      else @(negedge iCLK);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: event not seen within %0d cycles", name, maxc);
    end
  endtask

  initial begin
    string grants;
    int    reqCycles;
    int    doneCount;
    bit    prevReq;

    repeat (3) @(negedge iCLK);
    chk("reset_busy", 32'(oBUSY), 32'h0);
    chk("reset_mreq", 32'(oMREQ), 32'h0);
    chk("reset_ddone", 32'(oDDONE), 32'h0);
    iRST = 0;
    @(negedge iCLK);

    // Fetch, zero wait.
    memWait = 0; rdPattern = 32'hDEADBEEF;
    iIFREQ = 1; iIFADDR = 30'h40;
    @(negedge iCLK);
    chk("t1_mreq", 32'(oMREQ), 32'h1);
    chk("t1_maddr", oMADDR, 32'h100);
    chk("t1_mrw", 32'(oMRW), 32'h1);
    chk("t1_mbe", 32'(oMBE), 32'hF);
    @(negedge iCLK);
    chk("t1_ifdone", 32'(oIFDONE), 32'h1);
    chk("t1_ifrdata", oIFRDATA, 32'hDEADBEEF);
    chk("t1_iferr", 32'(oIFERR), 32'h0);
    $display("txn fetch 0x100 -> rdata %h err %0d", oIFRDATA, oIFERR);
    iIFREQ = 0;
    @(negedge iCLK);

    // Simultaneous: data byte store first, fetch next.
    rdPattern = 32'h11223344;
    iIFREQ = 1; iIFADDR = 30'h80;
    iDREQ = 1; iDRW = 0; iDADDR = 32'h1003; iDSIZE = 2'b00; iDWDATA = 32'h000000AB;
    @(negedge iCLK);
    chk("t2_mreq", 32'(oMREQ), 32'h1);
    chk("t2_mrw", 32'(oMRW), 32'h0);
    chk("t2_mbe", 32'(oMBE), 32'h8);
    chk("t2_mwdata", oMWDATA, 32'hABABABAB);
    @(negedge iCLK);
    chk("t2_ddone", 32'(oDDONE), 32'h1);
    $display("txn byte store 0x1003 done err %0d", oDERR);
    iDREQ = 0;
    @(negedge iCLK);
    @(negedge iCLK);
    chk("t2_fetch_maddr", oMADDR, 32'h200);
    chk("t2_fetch_mrw", 32'(oMRW), 32'h1);
    waitFor(1, 5, "t2_ifdone");
    $display("txn fetch 0x200 -> rdata %h", oIFRDATA);
    iIFREQ = 0;
    @(negedge iCLK);

    // Starvation: both held, zero-wait memory.
    iIFREQ = 1; iIFADDR = 30'h50;
    iDREQ = 1; iDRW = 1; iDADDR = 32'h3000; iDSIZE = 2'b10; iDWDATA = 32'h0;
    grants = ""; prevReq = 0;
    for (int c = 0; c < 200 && grants.len() < 10; c++) begin
      @(negedge iCLK);
      if (oMREQ && !prevReq) grants = {grants, (oMADDR == 32'h140) ? "I" : "D"};
      prevReq = oMREQ;
    end
    waitFor(1, 5, "t3_last_ifdone");
    iIFREQ = 0; iDREQ = 0;
    checks++;
    if (grants != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL t3_grants: got %s expected DDDDIDDDDI", grants);
    end
    $display("txn starvation grants %s", grants);
    @(negedge iCLK);

    // Timeout on a data read.
    memWait = -1;
    iDREQ = 1; iDRW = 1; iDADDR = 32'h4000; iDSIZE = 2'b10;
    reqCycles = 0;
    for (int c = 0; c < 40 && !oDDONE; c++) begin
      @(negedge iCLK);
      if (oMREQ) reqCycles++;
    end
    chk("t4_reqcycles", 32'(reqCycles), 32'd16);
    chk("t4_ddone", 32'(oDDONE), 32'h1);
    chk("t4_derr", 32'(oDERR), 32'h1);
    chk("t4_drdata", oDRDATA, 32'h0);
    $display("txn timeout read 0x4000 req cycles %0d err %0d", reqCycles, oDERR);
    iDREQ = 0;
    @(negedge iCLK);

    // Misaligned word load, with stray iMRDY while idle.
    strayRdy = 1;
    @(negedge iCLK);
    iDREQ = 1; iDRW = 1; iDADDR = 32'h2002; iDSIZE = 2'b10;
    @(negedge iCLK);
    chk("t5_mreq", 32'(oMREQ), 32'h0);
    chk("t5_ddone", 32'(oDDONE), 32'h1);
    chk("t5_derr", 32'(oDERR), 32'h1);
    $display("txn misaligned word 0x2002 err %0d", oDERR);
    iDREQ = 0; strayRdy = 0;
    @(negedge iCLK);

    // Legal half store at 0x2002 with two wait states.
    memWait = 2;
    iDREQ = 1; iDRW = 0; iDADDR = 32'h2002; iDSIZE = 2'b01; iDWDATA = 32'h00001234;
    @(negedge iCLK);
    chk("t6_mbe", 32'(oMBE), 32'hC);
    chk("t6_mwdata", oMWDATA, 32'h12341234);
    waitFor(2, 10, "t6_ddone");
    chk("t6_derr", 32'(oDERR), 32'h0);
    $display("txn half store 0x2002 err %0d", oDERR);
    iDREQ = 0;
    @(negedge iCLK);

    // Illegal size.
    iDREQ = 1; iDRW = 1; iDADDR = 32'h2000; iDSIZE = 2'b11;
    @(negedge iCLK);
    chk("t7_derr", 32'(oDERR), 32'h1);
    $display("txn illegal size err %0d", oDERR);
    iDREQ = 0;
    @(negedge iCLK);

    // Byte load at offset 1 with one wait state.
    memWait = 1; rdPattern = 32'hCAFEF00D;
    iDREQ = 1; iDRW = 1; iDADDR = 32'h6001; iDSIZE = 2'b00;
    waitFor(2, 10, "t8_ddone");
    chk("t8_drdata", oDRDATA, 32'hCAFEF00D);
    $display("txn byte load 0x6001 -> rdata %h", oDRDATA);
    iDREQ = 0;
    @(negedge iCLK);

    // Reset three cycles into a wait-stated store.
    memWait = -1;
    iDREQ = 1; iDRW = 0; iDADDR = 32'h5000; iDSIZE = 2'b10; iDWDATA = 32'h55AA55AA;
    reqCycles = 0;
    for (int c = 0; c < 10 && reqCycles < 3; c++) begin
      @(negedge iCLK);
      if (oMREQ) reqCycles++;
    end
    iRST = 1; iDREQ = 0;
    @(negedge iCLK);
    chk("t9_mreq", 32'(oMREQ), 32'h0);
    chk("t9_busy", 32'(oBUSY), 32'h0);
    iRST = 0;
    doneCount = 0;
    repeat (20) begin
      @(negedge iCLK);
      if (oDDONE) doneCount++;
    end
    chk("t9_no_done", 32'(doneCount), 32'h0);
    $display("txn reset mid-store: done pulses afterwards %0d", doneCount);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
